// File: rtl/control_pipe_unit.sv
// Decode/EX control stage: registered control word with a multi-cycle MUL hold FSM.
// Optional illegal-opcode trap is enabled by defining CU_ILLEGAL_TRAP_EN.
module control_pipe_unit #(
  parameter int unsigned OPW     = 6,
  parameter int unsigned CMDW    = 4,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            id_valid_i,
  input  logic [OPW-1:0]  id_opcode_i,
  output logic            id_ready_o,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            ex_valid_o,
  output logic            ex_busy_o,
  output logic [CMDW-1:0] alu_cmd_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            wb_enable_o,
  output logic [1:0]      branch_type_o,
  output logic            is_immediate_o,
  output logic            illegal_op_o
);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ex_valid_q, ex_valid_d, ex_busy_q, ex_busy_d;
  logic [CMDW-1:0] alu_cmd_q, alu_cmd_d;
  logic            mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic            wb_enable_q, wb_enable_d, is_imm_q, is_imm_d;
  logic [1:0]      branch_q, branch_d;

  logic [CMDW-1:0] dec_cmd;
  logic            dec_mr, dec_mw, dec_wb, dec_imm, dec_mul;
  logic [1:0]      dec_br;
  logic            accept;
`ifdef CU_ILLEGAL_TRAP_EN
  logic            dec_illegal, illegal_q, illegal_d;
`endif

  // Ready is forced low while reset is asserted.
  assign id_ready_o = rst_ni && (state_q == StIdle) && !stall_i && !flush_i;
  assign accept     = id_valid_i && id_ready_o;

  always_comb begin
    dec_cmd = '0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_wb  = 1'b0;
    dec_imm = 1'b0;
    dec_mul = 1'b0;
    dec_br  = 2'b00;
`ifdef CU_ILLEGAL_TRAP_EN
    dec_illegal = 1'b0;
`endif
    case (id_opcode_i)
      OPW'(0):  ;
      OPW'(1):  begin dec_cmd = CMDW'(4'b0000); dec_wb = 1'b1; end
      OPW'(3):  begin dec_cmd = CMDW'(4'b0010); dec_wb = 1'b1; end
      OPW'(5):  begin dec_cmd = CMDW'(4'b0100); dec_wb = 1'b1; end
      OPW'(6):  begin dec_cmd = CMDW'(4'b0101); dec_wb = 1'b1; end
      OPW'(7):  begin dec_cmd = CMDW'(4'b0110); dec_wb = 1'b1; end
      OPW'(8):  begin dec_cmd = CMDW'(4'b0111); dec_wb = 1'b1; end
      OPW'(9):  begin dec_cmd = CMDW'(4'b1000); dec_wb = 1'b1; end
      OPW'(10): begin dec_cmd = CMDW'(4'b1000); dec_wb = 1'b1; end
      OPW'(11): begin dec_cmd = CMDW'(4'b1001); dec_wb = 1'b1; end
      OPW'(12): begin dec_cmd = CMDW'(4'b1010); dec_wb = 1'b1; end
      OPW'(13): begin dec_cmd = CMDW'(4'b1011); dec_wb = 1'b1; dec_mul = 1'b1; end
      OPW'(32): begin dec_cmd = CMDW'(4'b0000); dec_wb = 1'b1; dec_imm = 1'b1; end
      OPW'(33): begin dec_cmd = CMDW'(4'b0010); dec_wb = 1'b1; dec_imm = 1'b1; end
      OPW'(36): begin dec_mr = 1'b1; dec_wb = 1'b1; end
      OPW'(37): dec_mw = 1'b1;
      OPW'(40): dec_br = 2'b01;
      OPW'(41): dec_br = 2'b10;
      OPW'(42): dec_br = 2'b11;
      default: begin
`ifdef CU_ILLEGAL_TRAP_EN
        dec_illegal = 1'b1;
`endif
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ex_valid_d  = ex_valid_q;
    ex_busy_d   = ex_busy_q;
    alu_cmd_d   = alu_cmd_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    wb_enable_d = wb_enable_q;
    branch_d    = branch_q;
    is_imm_d    = is_imm_q;
    if (flush_i) begin
      state_d     = StIdle;
      cnt_d       = 4'd0;
      ex_valid_d  = 1'b0;
      ex_busy_d   = 1'b0;
      alu_cmd_d   = '0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      wb_enable_d = 1'b0;
      branch_d    = 2'b00;
      is_imm_d    = 1'b0;
    end else if (!stall_i) begin
      unique case (state_q)
        StIdle: begin
          // Without an accept the control word drops back to all-zero.
          alu_cmd_d   = accept ? dec_cmd : '0;
          mem_read_d  = accept && dec_mr;
          mem_write_d = accept && dec_mw;
          wb_enable_d = accept && dec_wb;
          branch_d    = accept ? dec_br : 2'b00;
          is_imm_d    = accept && dec_imm;
          ex_valid_d  = accept && !dec_mul;
          ex_busy_d   = accept && dec_mul;
          cnt_d       = 4'd0;
          if (accept && dec_mul) begin
            state_d = StMul;
            cnt_d   = 4'(MUL_LAT - 1);
          end
        end
        StMul: begin
          if (cnt_q <= 4'd1) begin
            state_d    = StIdle;
            cnt_d      = 4'd0;
            ex_valid_d = 1'b1;
            ex_busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      ex_valid_q  <= 1'b0;
      ex_busy_q   <= 1'b0;
      alu_cmd_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      wb_enable_q <= 1'b0;
      branch_q    <= 2'b00;
      is_imm_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ex_valid_q  <= ex_valid_d;
      ex_busy_q   <= ex_busy_d;
      alu_cmd_q   <= alu_cmd_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      wb_enable_q <= wb_enable_d;
      branch_q    <= branch_d;
      is_imm_q    <= is_imm_d;
    end
  end

`ifdef CU_ILLEGAL_TRAP_EN
  always_comb begin
    illegal_d = illegal_q;
    if (flush_i) illegal_d = 1'b0;
    else if (!stall_i) illegal_d = accept && dec_illegal;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) illegal_q <= 1'b0;
    else         illegal_q <= illegal_d;
  end

  assign illegal_op_o = illegal_q;
`else
  assign illegal_op_o = 1'b0;
`endif

  assign ex_valid_o     = ex_valid_q;
  assign ex_busy_o      = ex_busy_q;
  assign alu_cmd_o      = alu_cmd_q;
  assign mem_read_o     = mem_read_q;
  assign mem_write_o    = mem_write_q;
  assign wb_enable_o    = wb_enable_q;
  assign branch_type_o  = branch_q;
  assign is_immediate_o = is_imm_q;

endmodule

// File: doc/control_pipe_unit.md
CONTROL_PIPE_UNIT -- requirements
Module: control_pipe_unit

Interface
REQ-001 The block SHALL have parameter OPW, default 6, meaning opcode width.
REQ-002 The block SHALL have parameter CMDW, default 4, meaning ALU command width.
REQ-003 The block SHALL have parameter MUL_LAT, default 4, meaning MUL occupancy in cycles (legal range 2..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port id_valid, input, 1 bit: an opcode is offered.
REQ-007 The block SHALL have port id_opcode, input, OPW bits: the offered opcode.
REQ-008 The block SHALL have port id_ready, output, 1 bit: the block accepts an opcode this cycle.
REQ-009 The block SHALL have port stall, input, 1 bit: hazard hold.
REQ-010 The block SHALL have port flush, input, 1 bit: branch-taken kill.
REQ-011 The block SHALL have port ex_valid, output, 1 bit: EX control word is valid.
REQ-012 The block SHALL have port ex_busy, output, 1 bit: a MUL is in progress.
REQ-013 The block SHALL have output ports alu_cmd (CMDW bits), mem_read (1), mem_write (1), wb_enable (1), branch_type (2) and is_immediate (1), all registered.
REQ-014 The block SHALL have port illegal_op, output, 1 bit: a registered flag for an undefined opcode.

Function
REQ-015 Decode SHALL use this table (opcode: cmd/flags): 0 NOP: all zero; 1 ADD: 0000,wb; 3 SUB: 0010,wb; 5 AND: 0100,wb; 6 OR: 0101,wb; 7 NOR: 0110,wb; 8 XOR: 0111,wb.
REQ-016 Decode SHALL continue the table: 9 SLA: 1000,wb; 10 SLL: 1000,wb; 11 SRA: 1001,wb; 12 SRL: 1010,wb; 13 MUL: 1011,wb,multicycle.
REQ-017 Decode SHALL complete the table: 32 ADDI: 0000,wb,imm; 33 SUBI: 0010,wb,imm; 36 LD: 0000,mem_read,wb; 37 ST: 0000,mem_write; 40 BEZ: br 01; 41 BNE: br 10; 42 JMP: br 11.
REQ-018 Any opcode not in the table SHALL decode as NOP, and alu_cmd SHALL never be X.
REQ-019 The FSM SHALL have two states, IDLE and MUL, and id_ready SHALL equal (state==IDLE) && !stall && !flush.
REQ-020 An opcode SHALL be accepted when id_valid && id_ready; its control word then appears registered on the next edge with ex_valid=1, giving 1-cycle latency.
REQ-021 In IDLE, with no accept and no stall, ex_valid SHALL be 0 and all control outputs SHALL be 0.
REQ-022 Accepting MUL SHALL move IDLE->MUL, load the counter with MUL_LAT-1, set ex_busy=1 and hold the MUL control word, with ex_valid=0 until the final cycle.
REQ-023 In MUL the counter SHALL decrement each non-stalled cycle; at counter==1 the next cycle SHALL show ex_valid=1 with ex_busy=0 and the state SHALL return to IDLE; ex_busy SHALL be high for exactly MUL_LAT-1 cycles.
REQ-024 While stall=1 (and flush=0), all registers including the counter and FSM state SHALL hold their values.
REQ-025 flush=1 SHALL take priority over stall and accept: on the next edge all control outputs, ex_valid, ex_busy and illegal_op SHALL be 0, the state SHALL be IDLE, and any in-progress MUL SHALL be aborted.
REQ-026 The counter width SHALL be 4 bits and SHALL never wrap below 0.

Reset
REQ-027 While rst=0, asynchronously, state SHALL be IDLE, the counter 0, and all outputs 0; id_ready SHALL be 0 during reset.
REQ-028 Reset mid-MUL SHALL abort the MUL with no ex_valid pulse.

Configuration
REQ-029 The macro CU_ILLEGAL_TRAP_EN SHALL control illegal-opcode trapping.
REQ-030 With CU_ILLEGAL_TRAP_EN defined, an accepted undefined opcode SHALL set illegal_op=1 for one cycle alongside ex_valid=1 and a NOP control word.
REQ-031 Without CU_ILLEGAL_TRAP_EN, illegal_op SHALL be tied to 0 and undefined opcodes SHALL be a silent NOP.

Verification
REQ-032 Bench SHALL cover reset release, then id_valid=1 with opcode 1 -> next cycle ex_valid=1, alu_cmd=0000, wb_enable=1, all other flags 0.
REQ-033 Bench SHALL cover opcode 36, then 37, then 42 back-to-back -> three consecutive ex_valid cycles with mem_read, then mem_write, then branch_type=11.
REQ-034 Bench SHALL cover opcode 13 with MUL_LAT=4 -> ex_busy high for 3 cycles, id_ready low meanwhile, ex_valid=1 with alu_cmd=1011 on the 4th cycle.
REQ-035 Bench SHALL cover a MUL with stall=1 for 2 cycles mid-operation -> completion delayed by exactly 2 cycles and outputs frozen throughout.
REQ-036 Bench SHALL cover flush during MUL cycle 2 together with a simultaneous stall -> next cycle all outputs 0, state IDLE, and id_ready=1 the following cycle.
REQ-037 Bench SHALL cover opcode 63 -> with CU_ILLEGAL_TRAP_EN, illegal_op=1 and a NOP control word; without it, illegal_op=0 and a NOP control word.
